// File: rtl/frame_streamer_pkg.sv
// -----------------------------------------------------------------------------
// frame_streamer_pkg
// Shared definitions for the frame streamer and its neighbours in the
// convolution chain.
//   fs_state_e  : streamer FSM state encoding
//   addr_width  : bit width needed to index a buffer of a given depth
//   FRAME_AW    : address width of the default 28x28 frame, shared with the
//                 window generator's raster counters
// -----------------------------------------------------------------------------
package frame_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_STREAM = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } fs_state_e;

    localparam int DEF_IX = 28;
    localparam int DEF_IY = 28;

    // A depth of 1 still needs a one-bit index.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FRAME_AW = addr_width(DEF_IX * DEF_IY);

endpackage

// File: rtl/frame_streamer_if.sv
// -----------------------------------------------------------------------------
// frame_streamer_if
// Pixel stream bundle between the frame streamer (master) and its consumer
// (slave).
//   o_out_valid : pixel valid, driven by the master
//   i_out_ready : downstream ready, driven by the slave
//   o_out_pixel : pixel value (PW bits)
//   o_sof       : pixel (0,0) of the frame
//   o_eol       : last pixel of a line
//   o_eof       : last pixel of the frame
// -----------------------------------------------------------------------------
interface frame_streamer_if #(
    parameter int PW = 8
);
    logic          o_out_valid;
    logic          i_out_ready;
    logic [PW-1:0] o_out_pixel;
    logic          o_sof;
    logic          o_eol;
    logic          o_eof;

    modport master (
        output o_out_valid,
        output o_out_pixel,
        output o_sof,
        output o_eol,
        output o_eof,
        input  i_out_ready
    );

    modport slave (
        input  o_out_valid,
        input  o_out_pixel,
        input  o_sof,
        input  o_eol,
        input  o_eof,
        output i_out_ready
    );
endinterface

// File: rtl/frame_streamer_ram.sv
// -----------------------------------------------------------------------------
// frame_ram
// Frame buffer: synchronous write, registered one-cycle read, no reset on the
// storage. Write and read use separate addresses so that the read of pixel 0
// issued by a start can coincide with a buffer write in the same idle cycle.
//   clk      : clock
//   we       : write strobe (caller has already range-checked wr_addr)
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address, sampled every cycle
//   rd_data  : registered read data; holds when rd_addr is out of range
// -----------------------------------------------------------------------------
module frame_ram
    import frame_streamer_pkg::*;
#(
    parameter  int DEPTH = 784,
    parameter  int WIDTH = 8,
    localparam int AW    = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // registered read; the streamer's prefetch may run one or two addresses
    // past the end of the frame, those reads are simply dropped
    always_ff @(posedge clk) begin
        if ({1'b0, rd_addr} < DEPTH_W) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// -----------------------------------------------------------------------------
// frame_streamer
// Holds one IX x IY frame and streams it in raster order over a valid/ready
// interface with start-of-frame, end-of-line and end-of-frame flags, optionally
// inserting LINE_GAP idle cycles between lines.
//   clk, reset_n          : clock, asynchronous active-low reset
//   i_wr_en/addr/data     : frame buffer write port (honoured only when idle)
//   i_start               : start streaming pulse (idle only)
//   i_abort               : abandon the current frame
//   o_busy                : high from start acceptance until done/abort
//   o_done                : one-cycle pulse after the last pixel handshake
//   out (master modport)  : pixel stream with flags
// -----------------------------------------------------------------------------
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter  int I_F_BW   = 8,
    parameter  int IX       = 28,
    parameter  int IY       = 28,
    parameter  int LINE_GAP = 0,
    localparam int AW       = addr_width(IX * IY)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [I_F_BW-1:0] i_wr_data,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    frame_streamer_if.master  out
);

    localparam int XW = addr_width(IX);
    localparam int YW = addr_width(IY);
    localparam int GW = addr_width(LINE_GAP + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(IX - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IY - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(IX * IY);

    fs_state_e         state_r, state_nxt_s;
    logic [XW-1:0]     x_r, x_nxt_s;
    logic [YW-1:0]     y_r, y_nxt_s;
    logic [AW-1:0]     idx_r, idx_nxt_s;
    logic [GW-1:0]     gap_r, gap_nxt_s;
    logic [AW-1:0]     rd_addr_s;
    logic [I_F_BW-1:0] rd_data_s;
    logic [I_F_BW-1:0] pixel_r;
    logic              valid_r, busy_r, done_r;
    logic              hs_s, load_px_s, we_s;

    // writes only land while idle and inside the frame
    assign we_s = i_wr_en && (state_r == ST_IDLE) && ({1'b0, i_wr_addr} < DEPTH_W);

    // valid is high exactly while in STREAM, so the handshake needs no valid term
    assign hs_s = (state_r == ST_STREAM) && out.i_out_ready;

    frame_ram #(
        .DEPTH (IX * IY),
        .WIDTH (I_F_BW)
    ) u_ram (
        .clk     (clk),
        .we      (we_s),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // next state, counters and prefetch address. The RAM output always holds
    // the pixel after the one on the output, so a handshake can reload the
    // output register at once while fetching two ahead.
    always_comb begin
        state_nxt_s = state_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        idx_nxt_s   = idx_r;
        gap_nxt_s   = gap_r;
        rd_addr_s   = idx_r + AW'(1);
        load_px_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rd_addr_s = '0;
                if (i_start && !i_abort) begin
                    state_nxt_s = ST_FETCH;
                    x_nxt_s     = '0;
                    y_nxt_s     = '0;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (i_abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STREAM;
                    load_px_s   = 1'b1;
                end
            end
            ST_STREAM: begin
                if (i_abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (hs_s) begin
                    rd_addr_s = idx_r + AW'(2);
                    idx_nxt_s = idx_r + AW'(1);
                    load_px_s = 1'b1;
                    if (x_r == X_LAST) begin
                        x_nxt_s = '0;
                        if (y_r == Y_LAST) begin
                            state_nxt_s = ST_DONE;
                            y_nxt_s     = '0;
                            idx_nxt_s   = '0;
                        end else begin
                            y_nxt_s = y_r + YW'(1);
                            if (LINE_GAP > 0) begin
                                state_nxt_s = ST_GAP;
                                gap_nxt_s   = GAP_LAST;
                            end else begin
                                state_nxt_s = ST_STREAM;
                            end
                        end
                    end else begin
                        x_nxt_s = x_r + XW'(1);
                    end
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_GAP: begin
                if (i_abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (gap_r == '0) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    gap_nxt_s = gap_r - GW'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // leaving for IDLE (abort or default recovery) always clears the counters
        if (state_nxt_s == ST_IDLE) begin
            x_nxt_s   = '0;
            y_nxt_s   = '0;
            idx_nxt_s = '0;
            gap_nxt_s = '0;
            load_px_s = 1'b0;
        end else begin
            gap_nxt_s = gap_nxt_s;
        end
    end

    // state, counters and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            x_r     <= '0;
            y_r     <= '0;
            idx_r   <= '0;
            gap_r   <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            x_r     <= x_nxt_s;
            y_r     <= y_nxt_s;
            idx_r   <= idx_nxt_s;
            gap_r   <= gap_nxt_s;
            valid_r <= (state_nxt_s == ST_STREAM);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // output pixel register, reloaded from the prefetched RAM word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_r <= '0;
        end else if (load_px_s) begin
            pixel_r <= rd_data_s;
        end
    end

    assign o_busy          = busy_r;
    assign o_done          = done_r;
    assign out.o_out_valid = valid_r;
    assign out.o_out_pixel = pixel_r;
    // flags track the counters of the pixel on the output and are masked by valid
    assign out.o_sof       = valid_r && (x_r == '0) && (y_r == '0);
    assign out.o_eol       = valid_r && (x_r == X_LAST);
    assign out.o_eof       = valid_r && (x_r == X_LAST) && (y_r == Y_LAST);

endmodule

// File: tb/tb_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_frame_streamer
// Scoreboard bench: two streamers (no line gap / 3-cycle line gap) share one
// loaded frame. Expected beats are derived from a raster-index model of the
// buffer and queued when a frame is started; a negedge monitor pops and compares
// on every handshake and also checks stall stability, gaps, done and timing.
// -----------------------------------------------------------------------------
module tb_frame_streamer;

    localparam int IX   = 28;
    localparam int IY   = 28;
    localparam int NPIX = IX * IY;
    localparam int BW   = 8;
    localparam int GAP1 = 3;
    localparam int AW   = frame_streamer_pkg::addr_width(NPIX);

    typedef struct packed {
        logic [BW-1:0] px;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en0, wr_en1;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          start0, start1, abort0, abort1;
    logic          busy0, busy1, done0, done1;

    frame_streamer_if #(.PW(BW)) if0 ();
    frame_streamer_if #(.PW(BW)) if1 ();

    frame_streamer #(.I_F_BW(BW), .IX(IX), .IY(IY), .LINE_GAP(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en0), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start0), .i_abort(abort0),
        .o_busy(busy0), .o_done(done0), .out(if0)
    );

    frame_streamer #(.I_F_BW(BW), .IX(IX), .IY(IY), .LINE_GAP(GAP1)) dut1 (
        .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en1), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start1), .i_abort(abort1),
        .o_busy(busy1), .o_done(done1), .out(if1)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] mem_model [NPIX];
    beat_t q0[$];
    beat_t q1[$];
    int    tests = 0;
    int    fails = 0;
    int    hs_cnt[2];
    int    done_cnt[2];
    bit    exact[2];
    bit    rmode;
    bit    prev_v[2], prev_r[2], prev_eof_hs[2], gap_pend[2], in_frame[2];
    beat_t prev_b[2];
    int    gap_run[2], frame_cyc[2];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t expect_beat(input int i);
        beat_t b;
        b.px  = mem_model[i];
        b.sof = (i == 0);
        b.eol = ((i % IX) == IX - 1);
        b.eof = (i == NPIX - 1);
        return b;
    endfunction

    task automatic push_frame(input int k);
        for (int i = 0; i < NPIX; i++) begin
            if (k == 0) q0.push_back(expect_beat(i));
            else        q1.push_back(expect_beat(i));
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mon(input int k, input logic v, input logic r, input beat_t b,
                       input logic d, input logic bz);
        beat_t e;
        int    expgap = (k == 1) ? GAP1 : 0;
        if (gap_pend[k]) begin
            if (!v) gap_run[k]++;
            else begin
                check($sformatf("line_gap_%0d", k), gap_run[k], expgap);
                gap_pend[k] = 1'b0;
            end
        end
        if (prev_v[k] && !prev_r[k]) begin
            check($sformatf("stall_valid_%0d", k), int'(v), 1);
            check($sformatf("stall_beat_%0d", k), int'(b), int'(prev_b[k]));
        end
        if (!v) check($sformatf("flags_idle_%0d", k), int'({b.sof, b.eol, b.eof}), 0);
        if (prev_eof_hs[k]) check($sformatf("done_pulse_%0d", k), int'({d, v, bz}), 5);
        else                check($sformatf("no_done_%0d", k), int'(d), 0);
        if (d) begin
            done_cnt[k]++;
            check($sformatf("queue_drained_%0d", k), qsize(k), 0);
            if (exact[k] && in_frame[k])
                check($sformatf("frame_cycles_%0d", k), frame_cyc[k], NPIX + (IY - 1) * expgap);
            in_frame[k] = 1'b0;
        end
        if (v && !in_frame[k]) begin
            in_frame[k]  = 1'b1;
            frame_cyc[k] = 0;
        end
        if (in_frame[k] && !d) frame_cyc[k]++;
        prev_eof_hs[k] = 1'b0;
        if (v && r) begin
            hs_cnt[k]++;
            check($sformatf("beat_expected_%0d", k), int'(qsize(k) > 0), 1);
            if (qsize(k) > 0) begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("beat_%0d", k), int'(b), int'(e));
                prev_eof_hs[k] = e.eof;
                if (e.eol && !e.eof) begin
                    gap_pend[k] = 1'b1;
                    gap_run[k]  = 0;
                end
            end
        end
        if (!bz) begin
            gap_pend[k] = 1'b0;
            if (!d) in_frame[k] = 1'b0;
        end
        prev_v[k] = v;
        prev_r[k] = r;
        prev_b[k] = b;
    endtask

    // monitor: samples both streams on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                for (int k = 0; k < 2; k++) begin
                    prev_v[k] = 1'b0; prev_r[k] = 1'b0; prev_eof_hs[k] = 1'b0;
                    gap_pend[k] = 1'b0; in_frame[k] = 1'b0; prev_b[k] = '0;
                end
            end else begin
                mon(0, if0.o_out_valid, if0.i_out_ready,
                    {if0.o_out_pixel, if0.o_sof, if0.o_eol, if0.o_eof}, done0, busy0);
                mon(1, if1.o_out_valid, if1.i_out_ready,
                    {if1.o_out_pixel, if1.o_sof, if1.o_eol, if1.o_eof}, done1, busy1);
            end
        end
    end

    // ready driver for the no-gap streamer: held high or pseudo-random
    initial begin
        if0.i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if0.i_out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_idle(input string name);
        check({name, "_0"}, int'({busy0, done0, if0.o_out_valid, if0.o_out_pixel,
                                  if0.o_sof, if0.o_eol, if0.o_eof}), 0);
        check({name, "_1"}, int'({busy1, done1, if1.o_out_valid, if1.o_out_pixel,
                                  if1.o_sof, if1.o_eol, if1.o_eof}), 0);
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk); #1;
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input string name, input int budget);
        int c0 = done_cnt[k];
        int n  = 0;
        while (done_cnt[k] == c0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, done_cnt[k] - c0, 1);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt[0] < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
    endtask

    initial begin
        int d0;
        reset_n = 1'b1; wr_en0 = 1'b0; wr_en1 = 1'b0; wr_addr = '0; wr_data = '0;
        start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        if1.i_out_ready = 1'b1; rmode = 1'b0;
        exact[0] = 1'b1; exact[1] = 1'b1;
        hs_cnt[0] = 0; hs_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle("reset_state");
        @(posedge clk); #1 reset_n = 1'b1;

        // load both buffers with index mod 256
        wr_en0 = 1'b1; wr_en1 = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            wr_addr = AW'(i);
            wr_data = BW'(i % 256);
            mem_model[i] = BW'(i % 256);
            @(posedge clk); #1;
        end
        wr_en0 = 1'b0; wr_en1 = 1'b0;

        // ready held high, start-to-valid latency
        push_frame(0);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        @(negedge clk) check("busy_before_valid", int'({busy0, if0.o_out_valid}), 2);
        @(negedge clk) check("first_valid_sof", int'({if0.o_out_valid, if0.o_sof}), 3);
        wait_done(0, "done_ready_high", 2000);

        // pseudo-random ready
        exact[0] = 1'b0; rmode = 1'b1;
        push_frame(0);
        pulse_start(0);
        wait_done(0, "done_random_ready", 8000);
        rmode = 1'b0;
        repeat (3) @(posedge clk);
        exact[0] = 1'b1;

        // line gap of 3 cycles
        push_frame(1);
        pulse_start(1);
        wait_done(1, "done_line_gap", 3000);

        // abort right after the pixel 100 handshake
        hs_cnt[0] = 0;
        push_frame(0);
        pulse_start(0);
        wait_hs(101);
        check("abort_point", hs_cnt[0], 101);
        #1 abort0 = 1'b1;
        @(posedge clk); #1 abort0 = 1'b0;
        q0.delete();
        @(negedge clk) check("abort_outputs", int'({if0.o_out_valid, busy0, done0}), 0);
        repeat (3) @(posedge clk);
        push_frame(0);
        pulse_start(0);
        wait_done(0, "done_after_abort", 2000);

        // mid-frame write and start are ignored
        hs_cnt[0] = 0;
        d0 = done_cnt[0];
        push_frame(0);
        pulse_start(0);
        wait_hs(50);
        #1 wr_en0 = 1'b1; wr_addr = AW'(5); wr_data = 8'hAA; start0 = 1'b1;
        @(posedge clk); #1 wr_en0 = 1'b0; start0 = 1'b0;
        wait_done(0, "done_mid_frame", 2000);
        repeat (20) @(posedge clk);
        check("single_done", done_cnt[0] - d0, 1);

        // asynchronous reset mid-frame, buffer retained
        hs_cnt[0] = 0;
        push_frame(0);
        pulse_start(0);
        wait_hs(200);
        @(posedge clk); #3 reset_n = 1'b0;
        #1 check_idle("reset_mid_frame");
        q0.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push_frame(0);
        pulse_start(0);
        wait_done(0, "done_after_reset", 2000);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
